// File: rtl/mux_gate_pipe.sv
// Purpose : per-lane 2-input gate selected by a 4-bit truth table, built only from 2:1 muxes, in a 2-stage pipe.
// Latency : 2 cycles from input handshake to out_vld; one transaction per cycle when out_rdy stays high.
// Backpress: out_rdy low holds S2; S1 fills behind it, then in_rdy drops until S2 drains.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_vld/in_rdy     upstream handshake for operands a, b and truth table tt
//   a, b [WIDTH]      operands; result bit i = tt[{a[i],b[i]}]
//   tt [4]            truth table (4'b1000 AND, 4'b1110 OR, 4'b0110 XOR)
//   out_vld/out_rdy   downstream handshake for result o
//   o [WIDTH]         registered result
//   done_cnt [CNT_W]  count of output handshakes, wraps
//   o_red [3]         {&o, |o, ^o}, registered with o; present only with MUX_GATE_PIPE_REDUCE_EN
module mux_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       tt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] o,
  output logic [CNT_W-1:0] done_cnt
`ifdef MUX_GATE_PIPE_REDUCE_EN
  ,
  output logic [2:0]       o_red
`endif
);

  // Operands travel with their own truth table so a tt change only affects later transactions.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       tt;
  } s1_t;

  s1_t              s1_q;
  logic             s1_full;
  logic             s2_full;
  logic             s1_adv;
  logic             s2_adv;
  logic             out_hs;
  logic [WIDTH-1:0] mux_res;

  // S2 moves when empty or being consumed; S1 moves only into a moving S2.
  // in_rdy therefore depends combinationally on out_rdy, which is what lets a
  // completely full pipe keep accepting while it drains.
  assign s2_adv  = !s2_full || out_rdy;
  assign s1_adv  = s1_full && s2_adv;
  assign in_rdy  = !s1_full || s1_adv;
  assign out_hs  = s2_full && out_rdy;
  assign out_vld = s2_full;

  // Lane datapath: a[i] picks within each b-column of the table, b[i] then
  // picks between the two columns.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic l1_b0;
    logic l1_b1;
    assign l1_b0       = s1_q.a[gi] ? s1_q.tt[2] : s1_q.tt[0];
    assign l1_b1       = s1_q.a[gi] ? s1_q.tt[3] : s1_q.tt[1];
    assign mux_res[gi] = s1_q.b[gi] ? l1_b1 : l1_b0;
  end

  // Stage 1: operand + truth-table register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full <= 1'b0;
      s1_q    <= '0;
    end else if (in_rdy) begin
      s1_full <= in_vld;
      if (in_vld) begin
        s1_q.a  <= a;
        s1_q.b  <= b;
        s1_q.tt <= tt;
      end
    end
  end

  // Stage 2: result register. o only changes when S2 advances, so it holds
  // steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_full <= 1'b0;
      o       <= '0;
    end else if (s2_adv) begin
      s2_full <= s1_full;
      if (s1_full) begin
        o <= mux_res;
      end
    end
  end

`ifdef MUX_GATE_PIPE_REDUCE_EN
  // Reductions are computed from the S1 result so they land in the same cycle as o.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_red <= 3'b000;
    end else if (s2_adv && s1_full) begin
      o_red <= {&mux_res, |mux_res, ^mux_res};
    end
  end
`endif

  // Completed-transaction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_hs) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_gate_pipe.sv
// Purpose : self-checking bench for mux_gate_pipe (table vectors plus multi-cycle sequences).
// Latency : n/a.
// Backpress: drives out_rdy directly.
module tb_mux_gate_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic       out_rdy;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] tt;

  logic        in_rdy;
  logic        out_vld;
  logic [7:0]  o;
  logic [15:0] done_cnt;
  logic        in_rdy4;
  logic        out_vld4;
  logic [7:0]  o4;
  logic [3:0]  done_cnt4;
`ifdef MUX_GATE_PIPE_REDUCE_EN
  logic [2:0]  o_red;
  logic [2:0]  o_red4;
`endif

  always #5 clk = ~clk;

  mux_gate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .a(a), .b(b), .tt(tt), .out_vld(out_vld), .out_rdy(out_rdy),
    .o(o), .done_cnt(done_cnt)
`ifdef MUX_GATE_PIPE_REDUCE_EN
    , .o_red(o_red)
`endif
  );

  // Narrow-counter instance sharing the same stimulus, used for wrap checks.
  mux_gate_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy4),
    .a(a), .b(b), .tt(tt), .out_vld(out_vld4), .out_rdy(out_rdy),
    .o(o4), .done_cnt(done_cnt4)
`ifdef MUX_GATE_PIPE_REDUCE_EN
    , .o_red(o_red4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tt;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [21];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle. Handshakes are observed at the falling edge with inputs
  // settled; results are compared against a scoreboard in order. Inputs are
  // changed by the caller 1 time unit after the rising edge.
  task automatic tick(input int exp_rdy, output bit hs);
    @(negedge clk);
    hs = 1'b0;
    if (exp_rdy >= 0) check("in_rdy", in_rdy, (exp_rdy != 0));
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stale_out: got %0h, expected no result", o);
        end else begin
          check("data_order", o, exp_q.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(model(a, b, tt));
        hs = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int exp_rdy);
    bit dummy;
    tick(exp_rdy, dummy);
  endtask

  // Reset with in_vld high: the request must be ignored.
  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
    a = 8'h5A; b = 8'hC3; tt = 4'h9;
    step(-1);
    step(-1);
    rst = 1'b0; in_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    int acc;

    // a=CC, b=AA puts {a,b}=0,1,2,3 on lanes 0..3 (and again on 4..7), so o = {tt,tt}.
    for (int i = 0; i < 16; i++) vecs[i] = '{8'hCC, 8'hAA, 4'(i), {4'(i), 4'(i)}};
    vecs[16] = '{8'hF0, 8'h3C, 4'b1000, 8'h30};  // AND
    vecs[17] = '{8'hF0, 8'h3C, 4'b1110, 8'hFC};  // OR
    vecs[18] = '{8'hF0, 8'h3C, 4'b0110, 8'hCC};  // XOR
    vecs[19] = '{8'hA5, 8'h0F, 4'b0001, 8'h50};  // NOR
    vecs[20] = '{8'hA5, 8'h0F, 4'b0100, 8'hA0};  // a AND NOT b

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; a = '0; b = '0; tt = '0;

    // Reset state.
    do_reset();
    check("rst_out_vld", out_vld, 0);
    check("rst_o", o, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_done_cnt4", done_cnt4, 0);
`ifdef MUX_GATE_PIPE_REDUCE_EN
    check("rst_o_red", o_red, 0);
`endif
    step(1);
    check("rst_ignored_vld0", out_vld, 0);
    step(-1);
    check("rst_ignored_vld1", out_vld, 0);

    // Truth-table vectors, one at a time.
    for (int i = 0; i < 21; i++) begin
      a = vecs[i].a; b = vecs[i].b; tt = vecs[i].tt; in_vld = 1'b1;
      tick(1, hs);
      in_vld = 1'b0;
      if (i == 0) check("latency_not_early", out_vld, 0);
      step(-1);
      check($sformatf("tbl%0d_vld", i), out_vld, 1);
      check($sformatf("tbl%0d_o", i), o, vecs[i].exp);
      step(-1);
    end

    // Streaming: 100 back-to-back with random operands and tables.
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom); b = 8'($urandom); tt = 4'($urandom_range(0, 15)); in_vld = 1'b1;
      step(1);
    end
    in_vld = 1'b0;
    step(-1); step(-1); step(-1);
    check("stream_done_cnt", done_cnt, 100);
    check("stream_done_cnt4", done_cnt4, 4);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: out_rdy low for 5 cycles with in_vld held high.
    do_reset();
    out_rdy = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      a = 8'(16 + acc); b = 8'h3C; tt = 4'b0110; in_vld = 1'b1;
      tick((k < 2) ? 1 : 0, hs);
      if (hs) acc++;
      if (k >= 1) begin
        check($sformatf("bp_vld%0d", k), out_vld, 1);
        check($sformatf("bp_hold%0d", k), o, 8'h2C);
      end
    end
    check("bp_accepted", acc, 2);
    in_vld = 1'b0; out_rdy = 1'b1;
    step(-1); step(-1); step(-1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_done_cnt", done_cnt, 2);

    // Mid-operation reset with two transactions in flight.
    do_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 8'(8'hC0 + k); b = 8'h0F; tt = 4'b1110; in_vld = 1'b1;
      step(1);
    end
    in_vld = 1'b0;
    check("mid_pre_cnt", done_cnt, 1);
    check("mid_pre_vld", out_vld, 1);
    rst = 1'b1;
    step(-1);
    check("mid_rst_vld", out_vld, 0);
    check("mid_rst_cnt", done_cnt, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check($sformatf("mid_no_stale%0d", k), out_vld, 0);
    end

    // Counter wrap on the 4-bit instance.
    do_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      a = 8'($urandom); b = 8'($urandom); tt = 4'($urandom_range(0, 15)); in_vld = 1'b1;
      step(1);
    end
    in_vld = 1'b0;
    step(-1); step(-1); step(-1);
    check("wrap_cnt4", done_cnt4, 1);
    check("wrap_cnt16", done_cnt, 17);

`ifdef MUX_GATE_PIPE_REDUCE_EN
    // Reduction outputs.
    do_reset();
    out_rdy = 1'b1;
    a = 8'hFF; b = 8'hFF; tt = 4'b1000; in_vld = 1'b1;
    step(1);
    in_vld = 1'b0;
    step(-1);
    check("red_o", o, 8'hFF);
    check("red_o_red", o_red, 3'b110);
    step(-1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
